// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] FAULT_INSTR = 32'h0;

endpackage

// File: rtl/fetch_imem.sv
// Word-addressed instruction store: synchronous write, combinational read.
// A read of the word being written in the same cycle returns the old contents.
module fetch_imem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, RUN/HALT FSM and IF/ID register; 1-cycle fetch latency, entry held while out_valid && !out_ready.
// Optional FETCH_STATS_EN adds fetched/stall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               XLEN       = 64,
  parameter int               IMEM_DEPTH = 1024,
  parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [XLEN-1:0]               out_pc,
  output logic [31:0]                   out_instr,
  output logic                          out_fault,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
`ifdef FETCH_STATS_EN
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   stat_fetched,
  output logic [31:0]                   stat_stall
`else
  input  logic [31:0]                   imem_wdata
`endif
);

  localparam int              AW         = $clog2(IMEM_DEPTH);
  localparam logic [XLEN-3:0] IMEM_WORDS = (XLEN-2)'(IMEM_DEPTH);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [31:0]     instr_q, instr_d;
  logic            fault_q, fault_d;

  logic [31:0]     imem_rdata;
  logic            fetch_fault;
  logic            advance;

  fetch_imem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc_q[AW+1:2]),
    .rdata (imem_rdata)
  );

  // Out-of-range words are detected on the full upper PC, not the truncated index.
  assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q[XLEN-1:2] >= IMEM_WORDS);
  assign advance     = !vld_q || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      epc_q   <= '0;
      instr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      epc_q   <= epc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    epc_d   = epc_q;
    instr_d = instr_q;
    fault_d = fault_q;

    if (redirect_valid) begin
      vld_d   = 1'b0;
      pc_d    = redirect_pc;
      state_d = RUN;
    end else if (advance) begin
      case (state_q)
        RUN: begin
          vld_d   = 1'b1;
          epc_d   = pc_q;
          instr_d = fetch_fault ? FAULT_INSTR : imem_rdata;
          fault_d = fetch_fault;
          if (fetch_fault) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
          end
        end
        HALT: begin
          vld_d = 1'b0;
        end
        default: begin
          state_d = HALT;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  assign out_valid = vld_q;
  assign out_pc    = epc_q;
  assign out_instr = instr_q;
  assign out_fault = fault_q;

`ifdef FETCH_STATS_EN
  // Counters observe the handshake only; a flush does not reset them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else if (vld_q) begin
      if (out_ready) begin
        stat_fetched <= stat_fetched + 32'd1;
      end else begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch stage: owns the PC register, word-addressed instruction memory and the IF/ID pipeline register in one block, with a valid/ready handshake to decode, redirect (branch/jump) flush and halt-on-fault. Sits at the front of the pipeline, feeding decode, and is redirected by the execute/branch unit.

## Interface
- XLEN, 64, PC/address width
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words; power of two, ≥ 4
- RESET_PC, 0, PC value after reset; must be 4-byte aligned
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  flush pipeline and load new PC
- redirect_pc  in  XLEN  redirect target
- out_ready  in  1  decode accepts the current IF/ID entry
- out_valid  out  1  IF/ID entry valid
- out_pc  out  XLEN  PC of the entry
- out_instr  out  32  instruction word of the entry
- out_fault  out  1  entry's PC was misaligned or out of range
- imem_we  in  1  instruction memory write enable (loader)
- imem_waddr  in  $clog2(IMEM_DEPTH)  word index
- imem_wdata  in  32  write data
- stat_fetched, stat_stall  out  32 each  only with FETCH_STATS_EN

## Operation
- State machine in {RUN, HALT}; reset → RUN, PC = RESET_PC, out_valid/out_pc/out_instr/out_fault = 0.
- Fault condition: PC[1:0] ≠ 0 or PC[XLEN-1:2] ≥ IMEM_DEPTH. Faulting entry carries out_instr = 0, out_fault = 1.
- Advance condition: !out_valid || out_ready.
- Priority per cycle: redirect > stall > fetch.
- Redirect (any state): out_valid ← 0, PC ← redirect_pc, state ← RUN. Misaligned redirect_pc is not rejected; it faults on the next fetch.
- RUN, advance: IF/ID ← {1, PC, imem[PC[$clog2(IMEM_DEPTH)+1:2]] or 0, fault}. No fault: PC ← PC + 4 (mod 2^XLEN). Fault: PC held, state ← HALT.
- RUN or HALT, stall (out_valid && !out_ready): all registers hold.
- HALT, advance: out_valid ← 0; no further fetch until redirect.
- imem write is synchronous on clk; a fetch of the word written in the same cycle returns the old contents.
- rst mid-stall or mid-HALT: immediate return to reset values; imem contents not cleared.

## Timing
- Fetch latency 1 cycle: PC presented in cycle n appears on out_* after edge n+1.
- Throughput 1 instruction/cycle while out_ready = 1.
- Redirect asserted in cycle n: out_valid = 0 in cycle n+1; redirect_pc entry valid in cycle n+2.
- Entry held stable while out_valid && !out_ready; it is consumed on the edge where both are 1.
- Fault entry presented once, then out_valid stays 0 in HALT.

## Configuration
- FETCH_STATS_EN defined: stat_fetched increments on each out_valid && out_ready edge. stat_stall increments on each out_valid && !out_ready edge. Both reset to 0 by rst, wrap at 2^32, and are unaffected by redirect.
- FETCH_STATS_EN undefined: counters and their ports are absent; all other behaviour is identical.

## Structure
- Package fetch_pkg: state enum (RUN, HALT), INSTR_BYTES = 4, FAULT_INSTR = 32'h0.
- Sub-module fetch_imem: storage array, synchronous write port and combinational read port (word index in, 32-bit word out).
- fetch_stage holds the PC, FSM, IF/ID register, fault check and optional counters.

## Test plan
- Load imem words 0..3 = A,B,C,D; release reset with out_ready = 1 → out_pc = 0,4,8,12 with A..D on consecutive cycles after the first edge.
- Hold out_ready = 0 for 3 cycles while out_pc = 4 → entry (4, B) stable; stat_stall = 3; resumes with (8, C).
- Redirect to 0x10 while out_pc = 4 → next cycle out_valid = 0; following cycle out_pc = 0x10.
- Redirect to 0x6 → one entry {pc = 6, fault = 1, instr = 0}, then out_valid = 0 indefinitely; a redirect to 0 restarts fetch at word 0.
- Sequential fetch reaches (IMEM_DEPTH-1)*4, then PC = IMEM_DEPTH*4 → fault entry and HALT.
- Assert rst during a stall with out_valid = 1 → all outputs 0 asynchronously; after release the first entry is at RESET_PC.
